// File: rtl/fa_seq_pkg.sv
// Shared types and defaults for the FA_NBIT request sequencer.
package fa_seq_pkg;

  localparam int FA_SIZE_DEF   = 16;
  localparam int FA_SETTLE_DEF = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } fa_seq_state_e;

endpackage

// File: rtl/fa_nbit_seq_driver.sv
// Sequences one add request onto the FA_NBIT shared operand bus and returns SUM/CO.
// Optional FA_SEQ_OVF_EN adds a captured signed-overflow flag (rsp_ovf).
module fa_nbit_seq_driver
  import fa_seq_pkg::*;
#(
  parameter int SIZE   = FA_SIZE_DEF,
  parameter int SETTLE = FA_SETTLE_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [SIZE-1:0] req_a,
  input  logic [SIZE-1:0] req_b,
  input  logic            req_ci,
  output logic [SIZE-1:0] add_I,
  output logic            add_sel,
  output logic            add_En,
  output logic            add_CI,
  input  logic [SIZE-1:0] add_SUM,
  input  logic            add_CO,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [SIZE-1:0] rsp_sum,
  output logic            rsp_co,
`ifdef FA_SEQ_OVF_EN
  output logic            rsp_ovf,
`endif
  output fa_seq_state_e   dbg_state
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid holds its payload stable until that edge.

  fa_seq_state_e   state;
  logic [CW-1:0]   cnt;
  logic [SIZE-1:0] b_q;
`ifdef FA_SEQ_OVF_EN
  logic            a_msb;
  logic            b_msb;
`endif

  assign dbg_state = state;

  // Bus outputs are registered one state ahead, so the value seen during
  // LOAD_A/LOAD_B is the operand the adder takes on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      b_q       <= '0;
      req_ready <= 1'b0;
      add_I     <= '0;
      add_sel   <= 1'b0;
      add_En    <= 1'b0;
      add_CI    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_co    <= 1'b0;
`ifdef FA_SEQ_OVF_EN
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            b_q       <= req_b;
            req_ready <= 1'b0;
            add_I     <= req_a;
            add_sel   <= 1'b0;
            add_En    <= 1'b1;
            add_CI    <= req_ci;
`ifdef FA_SEQ_OVF_EN
            a_msb     <= req_a[SIZE-1];
            b_msb     <= req_b[SIZE-1];
`endif
            state     <= LOAD_A;
          end else begin
            req_ready <= 1'b1;
          end
        end
        LOAD_A: begin
          add_I   <= b_q;
          add_sel <= 1'b1;
          add_En  <= 1'b1;
          state   <= LOAD_B;
        end
        LOAD_B: begin
          cnt   <= CW'(SETTLE - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_sum   <= add_SUM;
            rsp_co    <= add_CO;
`ifdef FA_SEQ_OVF_EN
            rsp_ovf   <= (a_msb == b_msb) && (add_SUM[SIZE-1] != a_msb);
`endif
            rsp_valid <= 1'b1;
            add_En    <= 1'b0;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fa_nbit_seq_driver.sv
// Directed bench for fa_nbit_seq_driver with a behavioural FA_NBIT model per instance.
module tb_fa_nbit_seq_driver;
  import fa_seq_pkg::*;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance with SETTLE=1 ----------------
  logic        req_valid = 1'b0, req_ready, req_ci = 1'b0;
  logic [15:0] req_a = '0, req_b = '0;
  logic [15:0] add_I, add_SUM;
  logic        add_sel, add_En, add_CI, add_CO;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_co;
  logic [15:0] rsp_sum;
  fa_seq_state_e dbg_state;
`ifdef FA_SEQ_OVF_EN
  logic        rsp_ovf;
`endif

  fa_nbit_seq_driver #(.SIZE(16), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ci(req_ci),
    .add_I(add_I), .add_sel(add_sel), .add_En(add_En), .add_CI(add_CI),
    .add_SUM(add_SUM), .add_CO(add_CO),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_co(rsp_co),
`ifdef FA_SEQ_OVF_EN
    .rsp_ovf(rsp_ovf),
`endif
    .dbg_state(dbg_state)
  );

  // FA_NBIT model: operand registers loaded through the shared bus.
  logic [15:0] m_a, m_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a <= '0; m_b <= '0;
    end else if (add_En) begin
      if (add_sel) m_b <= add_I;
      else         m_a <= add_I;
    end
  end
  assign {add_CO, add_SUM} = {1'b0, m_a} + {1'b0, m_b} + {16'd0, add_CI};

  // ---------------- instance with SETTLE=3 ----------------
  logic        s3_req_valid = 1'b0, s3_req_ready, s3_req_ci = 1'b0;
  logic [15:0] s3_req_a = '0, s3_req_b = '0;
  logic [15:0] s3_add_I, s3_add_SUM;
  logic        s3_add_sel, s3_add_En, s3_add_CI, s3_add_CO;
  logic        s3_rsp_valid, s3_rsp_ready = 1'b0, s3_rsp_co;
  logic [15:0] s3_rsp_sum;
  fa_seq_state_e s3_dbg_state;
`ifdef FA_SEQ_OVF_EN
  logic        s3_rsp_ovf;
`endif

  fa_nbit_seq_driver #(.SIZE(16), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(s3_req_valid), .req_ready(s3_req_ready),
    .req_a(s3_req_a), .req_b(s3_req_b), .req_ci(s3_req_ci),
    .add_I(s3_add_I), .add_sel(s3_add_sel), .add_En(s3_add_En), .add_CI(s3_add_CI),
    .add_SUM(s3_add_SUM), .add_CO(s3_add_CO),
    .rsp_valid(s3_rsp_valid), .rsp_ready(s3_rsp_ready),
    .rsp_sum(s3_rsp_sum), .rsp_co(s3_rsp_co),
`ifdef FA_SEQ_OVF_EN
    .rsp_ovf(s3_rsp_ovf),
`endif
    .dbg_state(s3_dbg_state)
  );

  logic [15:0] m3_a, m3_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m3_a <= '0; m3_b <= '0;
    end else if (s3_add_En) begin
      if (s3_add_sel) m3_b <= s3_add_I;
      else            m3_a <= s3_add_I;
    end
  end
  assign {s3_add_CO, s3_add_SUM} = {1'b0, m3_a} + {1'b0, m3_b} + {16'd0, s3_add_CI};

  // ---------------- driver tasks ----------------
  // Present a request; returns at #1 after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ci,
                      output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (ok) begin
      req_a = a; req_b = b; req_ci = ci; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  // Counts edges from the accepting edge until rsp_valid is seen.
  task automatic wait_rsp(output int lat, output bit timeout);
    lat = 0;
    timeout = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin lat = i; timeout = 1'b0; break; end
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %0b want 0", req_ready); end
    checks++; if ({add_I, add_sel, add_En, add_CI} !== 19'd0) begin errors++; $display("FAIL reset_add got I=%0d sel=%0b en=%0b ci=%0b want 0", add_I, add_sel, add_En, add_CI); end
    checks++; if ({rsp_valid, rsp_sum, rsp_co} !== 18'd0) begin errors++; $display("FAIL reset_rsp got v=%0b sum=%0d co=%0b want 0", rsp_valid, rsp_sum, rsp_co); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_rise got %0b want 1", req_ready); end
  endtask

  task automatic test_basic();
    bit ok, to; int lat;
    send(16'd500, 16'd400, 1'b0, ok);
    wait_rsp(lat, to);
    checks++; if (!ok || to || lat != 3) begin errors++; $display("FAIL basic_latency got %0d (ok=%0b to=%0b) want 3", lat, ok, to); end
    checks++; if (rsp_sum !== 16'd900 || rsp_co !== 1'b0) begin errors++; $display("FAIL basic_sum got %0d co=%0b want 900 co=0", rsp_sum, rsp_co); end
    checks++; if (add_En !== 1'b0) begin errors++; $display("FAIL basic_en_resp got %0b want 0", add_En); end
`ifdef FA_SEQ_OVF_EN
    checks++; if (rsp_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %0b want 0", rsp_ovf); end
`endif
    take_rsp();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL basic_handshake got v=%0b rdy=%0b want v=0 rdy=1", rsp_valid, req_ready); end
  endtask

  task automatic test_sel_sequence();
    bit ok, to; int lat;
    send(16'd400, 16'd400, 1'b1, ok);
    checks++; if (!ok || add_sel !== 1'b0 || add_En !== 1'b1 || add_I !== 16'd400 || add_CI !== 1'b1) begin errors++; $display("FAIL seq_load_a got sel=%0b en=%0b I=%0d ci=%0b want 0 1 400 1", add_sel, add_En, add_I, add_CI); end
    @(posedge clk); #1;
    checks++; if (add_sel !== 1'b1 || add_En !== 1'b1 || add_I !== 16'd400) begin errors++; $display("FAIL seq_load_b got sel=%0b en=%0b I=%0d want 1 1 400", add_sel, add_En, add_I); end
    wait_rsp(lat, to);
    checks++; if (to || rsp_sum !== 16'd801 || rsp_co !== 1'b0) begin errors++; $display("FAIL seq_sum got %0d co=%0b to=%0b want 801 co=0", rsp_sum, rsp_co, to); end
    take_rsp();
  endtask

  task automatic test_carry_out();
    bit ok, to; int lat;
    send(16'd32800, 16'd32800, 1'b0, ok);
    wait_rsp(lat, to);
    checks++; if (!ok || to || rsp_sum !== 16'd64 || rsp_co !== 1'b1) begin errors++; $display("FAIL carry_sum got %0d co=%0b want 64 co=1", rsp_sum, rsp_co); end
`ifdef FA_SEQ_OVF_EN
    checks++; if (rsp_ovf !== 1'b1) begin errors++; $display("FAIL carry_ovf got %0b want 1", rsp_ovf); end
`endif
    take_rsp();
  endtask

  task automatic test_backpressure();
    bit ok, to; int lat;
    send(16'd3, 16'd5, 1'b1, ok);
    wait_rsp(lat, to);
    checks++; if (!ok || to || rsp_sum !== 16'd9) begin errors++; $display("FAIL bp_first got %0d want 9", rsp_sum); end
    for (int i = 0; i < 4; i++) begin
      req_a = 16'(100 + i); req_b = 16'd7; req_valid = (i % 2 == 0);
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 16'd9 || req_ready !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d] got v=%0b sum=%0d rdy=%0b want 1 9 0", i, rsp_valid, rsp_sum, req_ready); end
    end
    req_valid = 1'b0;
    take_rsp();
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || add_En !== 1'b0 || dbg_state !== IDLE) begin errors++; $display("FAIL bp_after got v=%0b en=%0b st=%0d want 0 0 IDLE", rsp_valid, add_En, dbg_state); end
    // rsp_ready while idle must not invent a response
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL idle_rsp_ready got v=%0b rdy=%0b want 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_reset_mid_op();
    bit ok, to; int lat;
    send(16'd7, 16'd9, 1'b0, ok);
    @(posedge clk); #1;
    checks++; if (!ok || dbg_state !== LOAD_B) begin errors++; $display("FAIL mid_state got %0d want LOAD_B", dbg_state); end
    rst_n = 1'b0;
    #1;
    checks++; if (add_En !== 1'b0 || req_ready !== 1'b0 || add_I !== 16'd0 || add_sel !== 1'b0 || rsp_valid !== 1'b0 || rsp_sum !== 16'd0) begin errors++; $display("FAIL mid_reset got en=%0b rdy=%0b I=%0d sel=%0b v=%0b sum=%0d want all 0", add_En, req_ready, add_I, add_sel, rsp_valid, rsp_sum); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(16'd1, 16'd2, 1'b0, ok);
    wait_rsp(lat, to);
    checks++; if (!ok || to || lat != 3 || rsp_sum !== 16'd3 || rsp_co !== 1'b0) begin errors++; $display("FAIL mid_after got sum=%0d co=%0b lat=%0d want 3 0 3", rsp_sum, rsp_co, lat); end
    take_rsp();
  endtask

  task automatic test_settle3();
    int lat = 0;
    bit to = 1'b1;
    for (int i = 0; i < 20 && !s3_req_ready; i++) begin @(posedge clk); #1; end
    s3_req_a = 16'd65535; s3_req_b = 16'd1; s3_req_ci = 1'b0; s3_req_valid = 1'b1;
    @(posedge clk); #1;
    s3_req_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (s3_rsp_valid) begin lat = i; to = 1'b0; break; end
    end
    checks++; if (to || lat != 5) begin errors++; $display("FAIL settle3_latency got %0d want 5", lat); end
    checks++; if (s3_rsp_sum !== 16'd0 || s3_rsp_co !== 1'b1) begin errors++; $display("FAIL settle3_sum got %0d co=%0b want 0 co=1", s3_rsp_sum, s3_rsp_co); end
    s3_rsp_ready = 1'b1;
    @(posedge clk); #1;
    s3_rsp_ready = 1'b0;
    checks++; if (s3_rsp_valid !== 1'b0) begin errors++; $display("FAIL settle3_handshake got %0b want 0", s3_rsp_valid); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_sel_sequence();
    test_carry_out();
    test_backpressure();
    test_reset_mid_op();
    test_settle3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
